hdsiso_siso_n: RTL and testbench
================================

Name: hdsiso_siso_n

Overview:
- Parametrised successor of the 8-phase hyper-dense SISO delay line.
- Serial input bits are distributed round-robin over 2*JW shift banks. Bank selection comes from a JW-bit Johnson counter, so each bank shifts only on its own phase.
- Adds an internal LFSR source, a matching reference LFSR, and a built-in error checker with saturating counter and sticky flag.
- Sits between the clock/reset/input-mux plumbing and the top-level pins.

Parameters:
JW, 4, Johnson counter width; phases P = 2*JW
BANK_DEPTH, 4, bits per bank; total delay DEPTH = P*BANK_DEPTH (32 default)
LFSR_W, 8, LFSR width
LFSR_TAPS, 8'hB8, Galois feedback mask (maximal length)
LFSR_SEED, 1, nonzero reset/restart state
ERR_W, 8, error counter width

Ports:
CLK  in  1  clock, all state on rising edge
RESET  in  1  asynchronous, active-high reset
EN  in  1  shift enable; all delays count EN edges only
DIN_SEL  in  1  0: D_IN source, 1: internal LFSR source + checker
D_IN  in  1  external serial data
INJ  in  1  inverts the bit entering the banks (error injection)
CLR_ERR  in  1  synchronous clear of ERR_CNT/ERR_FLAG
D_OUT  out  1  delayed serial data (registered)
JOHNSON  out  JW  Johnson state
PULSES  out  P  one-hot phase decode of JOHNSON
LFSR_BIT  out  1  generator LFSR bit 0
LFSR_PERIOD  out  1  high while generator state == LFSR_SEED
PRIMED  out  1  checker armed
ERR_CNT  out  ERR_W  saturating mismatch count
ERR_FLAG  out  1  sticky mismatch flag

Behaviour:
- Reset values: JOHNSON=0, PULSES=1 (bit 0), banks=0, D_OUT=0, generator/reference LFSR=LFSR_SEED, prime count=0, PRIMED=0, ERR_CNT=0, ERR_FLAG=0, din_sel_q=0.
- Johnson: on each EN edge, J <= {J[JW-2:0], ~J[JW-1]}. Default sequence: 0000,0001,0011,0111,1111,1110,1100,1000, then repeats. EN=0 holds.
- Phase p = decode(J), 0..P-1. PULSES is a combinational one-hot decode of J.
- Source bit s = (DIN_SEL ? LFSR_BIT : D_IN) ^ INJ, sampled at the edge itself with no pre-register.
- On an EN edge at phase p:
  - D_OUT <= bank[p][BANK_DEPTH-1] (pre-shift value).
  - bank[p] shifts s into position 0.
  - Other banks hold.
- Latency: a bit sampled at EN edge k appears on D_OUT after EN edge k+DEPTH and holds for one EN interval.
- Generator LFSR advances on every EN edge (Galois, right shift, XOR with LFSR_TAPS when lsb=1).
- Restart edge: any edge where DIN_SEL != din_sel_q.
  - din_sel_q <= DIN_SEL.
  - Both LFSRs <= LFSR_SEED, prime count <= 0.
  - Banks, Johnson and D_OUT do not update (EN is ignored on this edge).
  - If DIN_SEL=1 at reset release, the first edge after reset is a restart edge.
- Prime count increments on each EN edge and saturates at DEPTH+1. PRIMED = DIN_SEL & (count == DEPTH+1).
- Checker: on each EN edge with PRIMED=1:
  - mismatch = D_OUT ^ ref[0].
  - Reference LFSR then advances.
  - Reference holds at seed while PRIMED=0.
- Errors: on mismatch, ERR_CNT increments and saturates at 2^ERR_W-1; ERR_FLAG <= 1. CLR_ERR wins over a simultaneous mismatch.
- Banks are not cleared on restart. Stale data is flushed before PRIMED rises.
- Async RESET mid-operation forces all reset values immediately, with no clock edge needed.

Decomposition:
- Shared package hdsiso_pkg holds:
  - johnson_next() and johnson_decode() functions
  - lfsr_next(state, taps) function
  - default LFSR_TAPS/LFSR_SEED constants
- One natural sub-module, lfsr_n (generic width/taps/seed, enable + sync restart), instantiated twice: generator and reference.

Test Plan:
- Reset with defaults -> D_OUT=0, JOHNSON=0000, PULSES=8'h01, LFSR_BIT=1, LFSR_PERIOD=1, ERR_CNT=0; assert RESET mid-stream -> same values before the next edge.
- EN=1 for 8 edges -> JOHNSON walks 0001,0011,0111,1111,1110,1100,1000,0000; PULSES one-hot 02,04,...,80,01; EN=0 for 5 edges -> no change.
- DIN_SEL=0, D_IN=1 only at EN edge 5 -> D_OUT=1 only after edge 37; insert 10 EN=0 cycles mid-stream -> D_OUT=1 appears exactly 10 clocks later.
- DIN_SEL 0->1 with EN=1 -> restart edge, then PRIMED=1 after 33 EN edges; 1000 edges with ERR_CNT=0; LFSR_PERIOD pulses every 255 EN edges.
- Primed self-test, INJ=1 for 3 isolated edges -> ERR_CNT=3, ERR_FLAG=1, each 33 edges after its injection; CLR_ERR coincident with a mismatch -> ERR_CNT=0, ERR_FLAG=0.
- ERR_W=2, 5 injections -> ERR_CNT saturates at 3; DIN_SEL 1->0 -> PRIMED=0, no further counting.

Source files
------------

// File: rtl/hdsiso_pkg.sv
// -----------------------------------------------------------------------------
// hdsiso_pkg
// Shared definitions for the parametrised hyper-dense SISO delay line:
//   - default LFSR feedback mask and seed
//   - source-select encoding
//   - johnson_next()   : one step of a jw-bit Johnson (twisted-ring) counter
//   - johnson_decode() : Johnson state -> phase number 0 .. 2*jw-1
//   - lfsr_next()      : one step of a right-shifting Galois LFSR
// The helpers work on 32-bit containers so one function serves every
// parameterisation; callers cast in and out of their own widths.
// -----------------------------------------------------------------------------
package hdsiso_pkg;

  // x^8 + x^6 + x^5 + x^4 + 1 : maximal length (period 255) for an 8-bit LFSR
  localparam logic [7:0] LFSR_TAPS_DEF = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEF = 8'h01;

  // Data source feeding the banks
  typedef enum logic {
    SRC_EXT  = 1'b0,  // external serial input
    SRC_LFSR = 1'b1   // internal generator, checker armed
  } src_sel_e;

  // Shift left, feeding back the inverted msb; bits above jw are forced to 0.
  function automatic logic [31:0] johnson_next(input logic [31:0] j, input int jw);
    logic [31:0] mask;
    mask = (32'h1 << jw) - 32'h1;  // jw == 32 wraps to all ones
    return ((j << 1) | {31'b0, ~j[jw-1]}) & mask;
  endfunction

  // While filling with ones (lsb set, or all zero) the phase is the number of
  // ones; while draining (lsb clear, not all zero) it is 2*jw minus that count.
  function automatic int johnson_decode(input logic [31:0] j, input int jw);
    int ones;
    ones = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < jw) ones += int'(j[i]);
    end
    if (j[0] || (ones == 0)) return ones;
    return (2 * jw) - ones;
  endfunction

  // Galois form: shift right, XOR the tap mask in when the bit shifted out is 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] taps);
    return (state >> 1) ^ (state[0] ? taps : 32'h0);
  endfunction

endpackage

// File: rtl/lfsr_n.sv
// -----------------------------------------------------------------------------
// lfsr_n
// Generic Galois LFSR (W <= 32) with clock enable and synchronous restart.
// Used twice in hdsiso_siso_n: as the pattern generator and as the checker's
// reference copy.
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous active-high reset, loads SEED
//   en_i       in   1  advance one step
//   restart_i  in   1  load SEED (wins over en_i)
//   state_o    out  W  current register state
// -----------------------------------------------------------------------------
module lfsr_n
  import hdsiso_pkg::*;
#(
  parameter int            W    = 8,
  parameter logic [W-1:0]  TAPS = W'(LFSR_TAPS_DEF),
  parameter logic [W-1:0]  SEED = W'(LFSR_SEED_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         restart_i,
  output logic [W-1:0] state_o
);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;

  always_comb begin
    // NOTE: next-state starts from the held value so every path assigns it;
    // leaving a path unassigned in combinational logic would infer a latch.
    state_d = state_q;
    if (restart_i) begin
      state_d = SEED;
    end else if (en_i) begin
      state_d = W'(lfsr_next(32'(state_q), 32'(TAPS)));
    end
  end

  // NOTE: registers use non-blocking assignment so all flops sample their
  // inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/hdsiso_siso_n.sv
// -----------------------------------------------------------------------------
// hdsiso_siso_n
// Parametrised hyper-dense SISO delay line. Serial bits are dealt round-robin
// over P = 2*JW shift banks of BANK_DEPTH bits; a JW-bit Johnson counter picks
// the bank, so only one bank shifts per enabled edge. Total delay is
// DEPTH = P*BANK_DEPTH enabled edges. An internal LFSR can replace the
// external input, and a reference LFSR plus checker counts corrupted bits.
//
// Ports:
//   CLK          in   1      clock, all state on rising edge
//   RESET        in   1      asynchronous active-high reset
//   EN           in   1      shift enable; delays count enabled edges only
//   DIN_SEL      in   1      0: D_IN source, 1: internal LFSR + checker
//   D_IN         in   1      external serial data
//   INJ          in   1      inverts the bit entering the banks
//   CLR_ERR      in   1      synchronous clear of ERR_CNT / ERR_FLAG
//   D_OUT        out  1      delayed serial data (registered)
//   JOHNSON      out  JW     Johnson counter state
//   PULSES       out  2*JW   one-hot phase decode of JOHNSON
//   LFSR_BIT     out  1      generator LFSR bit 0
//   LFSR_PERIOD  out  1      generator state equals the seed
//   PRIMED       out  1      checker armed
//   ERR_CNT      out  ERR_W  saturating mismatch count
//   ERR_FLAG     out  1      sticky mismatch flag
// -----------------------------------------------------------------------------
module hdsiso_siso_n
  import hdsiso_pkg::*;
#(
  parameter int                 JW         = 4,
  parameter int                 BANK_DEPTH = 4,
  parameter int                 LFSR_W     = 8,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS  = LFSR_W'(LFSR_TAPS_DEF),
  parameter logic [LFSR_W-1:0]  LFSR_SEED  = LFSR_W'(LFSR_SEED_DEF),
  parameter int                 ERR_W      = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic              DIN_SEL,
  input  logic              D_IN,
  input  logic              INJ,
  input  logic              CLR_ERR,
  output logic              D_OUT,
  output logic [JW-1:0]     JOHNSON,
  output logic [2*JW-1:0]   PULSES,
  output logic              LFSR_BIT,
  output logic              LFSR_PERIOD,
  output logic              PRIMED,
  output logic [ERR_W-1:0]  ERR_CNT,
  output logic              ERR_FLAG
);

  localparam int P     = 2 * JW;
  localparam int DEPTH = P * BANK_DEPTH;
  localparam int PH_W  = (P > 1) ? $clog2(P) : 1;
  localparam int PC_W  = $clog2(DEPTH + 2);
  // First D_OUT value guaranteed to come from the current source is the one
  // loaded on enabled edge DEPTH after a restart, so arm one edge later.
  localparam logic [PC_W-1:0] PRIME_MAX = PC_W'(DEPTH + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [JW-1:0]                  j_q,        j_d;
  logic [P-1:0][BANK_DEPTH-1:0]   bank_q,     bank_d;
  logic                           d_out_q,    d_out_d;
  src_sel_e                       din_sel_q,  din_sel_d;
  logic [PC_W-1:0]                prime_q,    prime_d;
  logic [ERR_W-1:0]               err_cnt_q,  err_cnt_d;
  logic                           err_flag_q, err_flag_d;

  logic [LFSR_W-1:0] gen_state;
  logic [LFSR_W-1:0] ref_state;

  logic [PH_W-1:0] phase;
  logic            restart;
  logic            shift_en;
  logic            src_bit;
  logic            primed;
  logic            check_en;
  logic            mismatch;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign din_sel_d = src_sel_e'(DIN_SEL);

  // A change of source resynchronises generator and reference; the datapath
  // freezes for that one edge so EN is ignored there.
  assign restart   = (din_sel_d != din_sel_q);
  assign shift_en  = EN & ~restart;

  assign phase     = PH_W'(johnson_decode(32'(j_q), JW));

  // Sampled directly at the edge: no input register in front of the banks.
  assign src_bit   = ((din_sel_d == SRC_LFSR) ? gen_state[0] : D_IN) ^ INJ;

  assign primed    = DIN_SEL & (prime_q == PRIME_MAX);
  assign check_en  = shift_en & primed;
  assign mismatch  = check_en & (d_out_q ^ ref_state[0]);

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    j_d        = j_q;
    bank_d     = bank_q;
    d_out_d    = d_out_q;
    prime_d    = prime_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;

    if (shift_en) begin
      j_d           = JW'(johnson_next(32'(j_q), JW));
      // Output takes the bit leaving the active bank before it shifts.
      d_out_d       = bank_q[phase][BANK_DEPTH-1];
      bank_d[phase] = (bank_q[phase] << 1) | BANK_DEPTH'(src_bit);
    end

    // Banks are not flushed on restart: the priming delay outlasts stale data.
    if (restart) begin
      prime_d = '0;
    end else if (EN && (prime_q != PRIME_MAX)) begin
      prime_d = prime_q + PC_W'(1);
    end

    // Clear has priority over a mismatch on the same edge.
    if (CLR_ERR) begin
      err_cnt_d  = '0;
      err_flag_d = 1'b0;
    end else if (mismatch) begin
      err_flag_d = 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      j_q        <= '0;
      // NOTE: the banks are a handful of flops, not a RAM, so they take the
      // async reset like everything else and D_OUT starts from known zeros.
      bank_q     <= '0;
      d_out_q    <= 1'b0;
      din_sel_q  <= SRC_EXT;
      prime_q    <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      j_q        <= j_d;
      bank_q     <= bank_d;
      d_out_q    <= d_out_d;
      din_sel_q  <= din_sel_d;
      prime_q    <= prime_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // LFSRs: generator runs on every enabled edge, reference only while checking
  // ---------------------------------------------------------------------------
  lfsr_n #(
    .W    (LFSR_W),
    .TAPS (LFSR_TAPS),
    .SEED (LFSR_SEED)
  ) u_gen (
    .clk       (CLK),
    .rst       (RESET),
    .en_i      (EN),
    .restart_i (restart),
    .state_o   (gen_state)
  );

  lfsr_n #(
    .W    (LFSR_W),
    .TAPS (LFSR_TAPS),
    .SEED (LFSR_SEED)
  ) u_ref (
    .clk       (CLK),
    .rst       (RESET),
    .en_i      (check_en),
    .restart_i (restart),
    .state_o   (ref_state)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    PULSES        = '0;
    PULSES[phase] = 1'b1;
  end

  assign D_OUT       = d_out_q;
  assign JOHNSON     = j_q;
  assign LFSR_BIT    = gen_state[0];
  assign LFSR_PERIOD = (gen_state == LFSR_SEED);
  assign PRIMED      = primed;
  assign ERR_CNT     = err_cnt_q;
  assign ERR_FLAG    = err_flag_q;

endmodule

// File: tb/tb_hdsiso_siso_n.sv
// -----------------------------------------------------------------------------
// tb_hdsiso_siso_n
// Bench for hdsiso_siso_n. Two instances share all inputs: default
// parameters, and ERR_W=2 for counter saturation. The reference model treats
// the delay line as a DEPTH-deep FIFO of sampled bits and tracks phase, LFSRs,
// priming and error counts as plain integers.
// -----------------------------------------------------------------------------
module tb_hdsiso_siso_n;

  localparam int JW    = 4;
  localparam int P     = 2 * JW;
  localparam int DEPTH = 32;
  localparam int SEED  = 1;
  localparam int TAPS  = 'hB8;

  logic       CLK = 1'b0;
  logic       RESET, EN, DIN_SEL, D_IN, INJ, CLR_ERR;
  logic       D_OUT, LFSR_BIT, LFSR_PERIOD, PRIMED, ERR_FLAG;
  logic [3:0] JOHNSON;
  logic [7:0] PULSES;
  logic [7:0] ERR_CNT;
  logic       D_OUT_w2, LFSR_BIT_w2, LFSR_PERIOD_w2, PRIMED_w2, ERR_FLAG_w2;
  logic [3:0] JOHNSON_w2;
  logic [7:0] PULSES_w2;
  logic [1:0] ERR_CNT_w2;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int m_phase, m_gen, m_ref, m_prime, m_err, m_err2, m_flag, m_dout, m_dsel;
  int hist[$];

  always #5 CLK = ~CLK;

  hdsiso_siso_n u_dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .DIN_SEL(DIN_SEL), .D_IN(D_IN),
    .INJ(INJ), .CLR_ERR(CLR_ERR), .D_OUT(D_OUT), .JOHNSON(JOHNSON),
    .PULSES(PULSES), .LFSR_BIT(LFSR_BIT), .LFSR_PERIOD(LFSR_PERIOD),
    .PRIMED(PRIMED), .ERR_CNT(ERR_CNT), .ERR_FLAG(ERR_FLAG)
  );

  hdsiso_siso_n #(.ERR_W(2)) u_dut_w2 (
    .CLK(CLK), .RESET(RESET), .EN(EN), .DIN_SEL(DIN_SEL), .D_IN(D_IN),
    .INJ(INJ), .CLR_ERR(CLR_ERR), .D_OUT(D_OUT_w2), .JOHNSON(JOHNSON_w2),
    .PULSES(PULSES_w2), .LFSR_BIT(LFSR_BIT_w2), .LFSR_PERIOD(LFSR_PERIOD_w2),
    .PRIMED(PRIMED_w2), .ERR_CNT(ERR_CNT_w2), .ERR_FLAG(ERR_FLAG_w2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int galois(input int x);
    return (x >> 1) ^ (((x & 1) != 0) ? TAPS : 0);
  endfunction

  // Johnson pattern for phase p: p low ones while filling, then ones drain
  // from the bottom.
  function automatic int exp_johnson(input int p);
    if (p <= JW) return (1 << p) - 1;
    return ((1 << JW) - 1) & ~((1 << (p - JW)) - 1);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_gen = SEED; m_ref = SEED; m_prime = 0;
    m_err = 0; m_err2 = 0; m_flag = 0; m_dout = 0; m_dsel = 0;
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(0);
  endtask

  task automatic model_edge();
    int  s;
    int  mism;
    bit  restart;
    bit  primed_pre;
    restart    = (int'(DIN_SEL) != m_dsel);
    primed_pre = DIN_SEL && (m_prime == DEPTH + 1);
    mism       = 0;
    if (restart) begin
      m_dsel = int'(DIN_SEL); m_gen = SEED; m_ref = SEED; m_prime = 0;
    end else if (EN) begin
      s = (DIN_SEL ? (m_gen & 1) : int'(D_IN)) ^ int'(INJ);
      if (primed_pre) begin
        mism  = m_dout ^ (m_ref & 1);
        m_ref = galois(m_ref);
      end
      hist.push_back(s);
      m_dout  = hist.pop_front();
      m_phase = (m_phase + 1) % P;
      m_gen   = galois(m_gen);
      if (m_prime < DEPTH + 1) m_prime++;
    end
    if (CLR_ERR) begin
      m_err = 0; m_err2 = 0; m_flag = 0;
    end else if (mism != 0) begin
      if (m_err < 255) m_err++;
      if (m_err2 < 3) m_err2++;
      m_flag = 1;
    end
  endtask

  task automatic compare_all();
    int exp_primed;
    exp_primed = (DIN_SEL && (m_prime == DEPTH + 1)) ? 1 : 0;
    check("d_out",        32'(D_OUT),          m_dout);
    check("johnson",      32'(JOHNSON),        exp_johnson(m_phase));
    check("pulses",       32'(PULSES),         1 << m_phase);
    check("lfsr_bit",     32'(LFSR_BIT),       m_gen & 1);
    check("lfsr_period",  32'(LFSR_PERIOD),    (m_gen == SEED) ? 1 : 0);
    check("primed",       32'(PRIMED),         exp_primed);
    check("err_cnt",      32'(ERR_CNT),        m_err);
    check("err_flag",     32'(ERR_FLAG),       m_flag);
    check("w2_d_out",     32'(D_OUT_w2),       m_dout);
    check("w2_johnson",   32'(JOHNSON_w2),     exp_johnson(m_phase));
    check("w2_pulses",    32'(PULSES_w2),      1 << m_phase);
    check("w2_lfsr_bit",  32'(LFSR_BIT_w2),    m_gen & 1);
    check("w2_period",    32'(LFSR_PERIOD_w2), (m_gen == SEED) ? 1 : 0);
    check("w2_primed",    32'(PRIMED_w2),      exp_primed);
    check("w2_err_cnt",   32'(ERR_CNT_w2),     m_err2);
    check("w2_err_flag",  32'(ERR_FLAG_w2),    m_flag);
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_d_out"},   32'(D_OUT),       0);
    check({tag, "_johnson"}, 32'(JOHNSON),     0);
    check({tag, "_pulses"},  32'(PULSES),      'h01);
    check({tag, "_lbit"},    32'(LFSR_BIT),    1);
    check({tag, "_lper"},    32'(LFSR_PERIOD), 1);
    check({tag, "_primed"},  32'(PRIMED),      0);
    check({tag, "_errcnt"},  32'(ERR_CNT),     0);
    check({tag, "_errflag"}, 32'(ERR_FLAG),    0);
    check({tag, "_w2cnt"},   32'(ERR_CNT_w2),  0);
  endtask

  // Assert reset between edges and look at outputs before any edge arrives.
  task automatic apply_reset(input string tag);
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1 check_reset_vals(tag);
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic inject_and_check(input int n, input bit clr_on_hit);
    INJ = 1'b1;
    cycle();
    INJ = 1'b0;
    repeat (32) cycle();
    check("inj_before_hit", 32'(ERR_CNT), (n - 1 > 255) ? 255 : n - 1);
    CLR_ERR = clr_on_hit;
    cycle();
    CLR_ERR = 1'b0;
    check("inj_hit_cnt",  32'(ERR_CNT),    clr_on_hit ? 0 : n);
    check("inj_hit_w2",   32'(ERR_CNT_w2), clr_on_hit ? 0 : ((n > 3) ? 3 : n));
    check("inj_hit_flag", 32'(ERR_FLAG),   clr_on_hit ? 0 : 1);
    repeat (10) cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int jtab[8];
    int first;
    int highs;
    int edges;
    int last;

    jtab = '{1, 3, 7, 15, 14, 12, 8, 0};
    RESET = 1'b1; EN = 1'b0; DIN_SEL = 1'b0; D_IN = 1'b0; INJ = 1'b0; CLR_ERR = 1'b0;
    #3 check_reset_vals("por");
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();

    // Johnson walk and hold
    EN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("jwalk", 32'(JOHNSON), jtab[i]);
      check("pwalk", 32'(PULSES),  1 << ((i + 1) % 8));
    end
    EN = 1'b0;
    repeat (5) begin
      cycle();
      check("jhold", 32'(JOHNSON), 0);
    end

    // Single marked bit: appears after enabled edge 37, for one interval
    EN = 1'b1;
    cycle(); cycle();
    apply_reset("mid");
    first = -1; highs = 0;
    for (int e = 1; e <= 45; e++) begin
      D_IN = (e == 5);
      cycle();
      if (D_OUT) begin
        highs++;
        if (first < 0) first = e;
      end
    end
    check("mark_edge",  first, 37);
    check("mark_width", highs, 1);

    // Same with a 10-clock EN gap: arrival shifts by exactly 10 clocks
    apply_reset("rst2");
    first = -1;
    for (int c = 1; c <= 60; c++) begin
      EN   = !((c > 20) && (c <= 30));
      D_IN = (c == 5);
      cycle();
      if (D_OUT && (first < 0)) first = c;
    end
    check("mark_stall", first, 47);

    // Self-test: restart edge, priming, long clean run, LFSR period
    apply_reset("rst3");
    EN = 1'b1; D_IN = 1'b0; DIN_SEL = 1'b1;
    cycle();
    check("restart_j", 32'(JOHNSON), 0);
    edges = 0;
    while (!PRIMED && (edges < 100)) begin
      cycle();
      edges++;
    end
    check("prime_edges", edges, 33);
    last = -1;
    for (int e = 1; e <= 1000; e++) begin
      cycle();
      if (LFSR_PERIOD) begin
        if (last >= 0) check("lfsr_gap", e - last, 255);
        last = e;
      end
    end
    check("clean_errcnt", 32'(ERR_CNT), 0);

    // Injections: five counted, then one cleared on its hit edge, one more
    for (int n = 1; n <= 5; n++) inject_and_check(n, 1'b0);
    inject_and_check(6, 1'b1);
    inject_and_check(1, 1'b0);

    // Leaving self-test disarms the checker
    DIN_SEL = 1'b0;
    cycle();
    check("disarm_primed", 32'(PRIMED), 0);
    for (int i = 0; i < 60; i++) begin
      INJ  = 1'($urandom_range(0, 1));
      D_IN = 1'($urandom);
      cycle();
    end
    INJ = 1'b0;
    check("disarm_errcnt", 32'(ERR_CNT), 1);

    // Randomised traffic against the model, with one mid-stream reset
    DIN_SEL = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) apply_reset("rnd");
      EN      = ($urandom_range(0, 3) != 0);
      D_IN    = 1'($urandom);
      INJ     = ($urandom_range(0, 39) == 0);
      CLR_ERR = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 299) == 0) DIN_SEL = ~DIN_SEL;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
